// File: rtl/uart_pkg.sv
// Shared definitions for the 8051-style serial port (transmit and receive paths).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      BIT9  = 3'd3,
      STOP  = 3'd4
   } tx_state_e;

   localparam logic [1:0] MODE0 = 2'd0;
   localparam logic [1:0] MODE1 = 2'd1;
   localparam logic [1:0] MODE2 = 2'd2;
   localparam logic [1:0] MODE3 = 2'd3;

   localparam logic [7:0] SCON_SFR_ADDR = 8'h98;
   localparam logic [7:0] SBUF_SFR_ADDR = 8'h99;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-time generator for the transmitter: 16x oversample counter for modes 1-3
// and the two-phase T7 shift clock for mode 0.
module uart_tx_baud
   import uart_pkg::*;
#(
   parameter int OVS_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_i,
   input  logic [1:0] mode_i,
   input  logic       tc_i,
   input  logic       t7_i,
   output logic       phase_o,
   output logic       bit_tick_o
);

   logic [OVS_W-1:0] ovsCnt_q, ovsCnt_d;
   logic             phase_q, phase_d;
   logic             syncMode;

   assign syncMode = (mode_i == MODE0);

   // Held at zero while idle, so a load always starts a full bit time even
   // when TC or T7 lands in the same cycle as the SBUF write.
   always_comb begin
      ovsCnt_d = ovsCnt_q;
      phase_d  = phase_q;
      if (!run_i) begin
         ovsCnt_d = '0;
         phase_d  = 1'b0;
      end else if (syncMode) begin
         if (t7_i) phase_d = ~phase_q;
      end else if (tc_i) begin
         ovsCnt_d = ovsCnt_q + OVS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovsCnt_q <= '0;
         phase_q  <= 1'b0;
      end else begin
         ovsCnt_q <= ovsCnt_d;
         phase_q  <= phase_d;
      end
   end

   assign phase_o    = phase_q;
   assign bit_tick_o = run_i && (syncMode ? (t7_i && phase_q)
                                          : (tc_i && (&ovsCnt_q)));

endmodule

// File: rtl/uart_transmit.sv
// Transmit half of the 8051 serial port. Define TX_HOLD_EN to add a one-entry
// holding register that chains a second frame without an idle bit time.
module uart_transmit
   import uart_pkg::*;
#(
   parameter logic [7:0] SBUF_ADDR = SBUF_SFR_ADDR,
   parameter int         OVS_W     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] AB,
   input  logic [7:0] din,
   input  logic       wr_n,
   input  logic [1:0] SM,
   input  logic       TB8,
   input  logic       TC,
   input  logic       T7,
   output logic       txd,
   output logic       rxd_out,
   output logic       rxd_oe,
   output logic       busy,
   output logic       TI
);

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic [1:0] mode_q, mode_d;
   logic       tb8_q, tb8_d;
   logic       ti_q, ti_d;
   logic       sbufWrite, bitTick, phase, frameDone, startFrame;
   logic [7:0] startData;
`ifdef TX_HOLD_EN
   logic [7:0] holdData_q, holdData_d;
   logic       holdFull_q, holdFull_d;
`endif

   assign sbufWrite = !wr_n && (AB == SBUF_ADDR);
   assign busy      = (state_q != IDLE);

   uart_tx_baud #(.OVS_W(OVS_W)) u_baud (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_i      (busy),
      .mode_i     (mode_q),
      .tc_i       (TC),
      .t7_i       (T7),
      .phase_o    (phase),
      .bit_tick_o (bitTick)
   );

   // Frame sequencing; a new frame (fresh load or held byte) overrides the
   // end-of-frame return to IDLE and samples SM/TB8 at that moment.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bitCnt_d   = bitCnt_q;
      mode_d     = mode_q;
      tb8_d      = tb8_q;
      frameDone  = 1'b0;
      startFrame = (state_q == IDLE) && sbufWrite;
      startData  = din;
`ifdef TX_HOLD_EN
      holdData_d = holdData_q;
      holdFull_d = holdFull_q;
`endif
      case (state_q)
         START: if (bitTick) state_d = DATA;
         DATA: begin
            if (bitTick) begin
               shift_d  = {1'b0, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  if (mode_q == MODE0) begin
                     state_d   = IDLE;
                     frameDone = 1'b1;
                  end else if (mode_q == MODE1) begin
                     state_d = STOP;
                  end else begin
                     state_d = BIT9;
                  end
               end
            end
         end
         BIT9: if (bitTick) state_d = STOP;
         STOP: begin
            if (bitTick) begin
               state_d   = IDLE;
               frameDone = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef TX_HOLD_EN
      if (busy && sbufWrite && !holdFull_q) begin
         holdFull_d = 1'b1;
         holdData_d = din;
      end
      if (frameDone && holdFull_d) begin
         startFrame = 1'b1;
         startData  = holdData_d;
         holdFull_d = 1'b0;
      end
`endif
      if (startFrame) begin
         state_d  = (SM == MODE0) ? DATA : START;
         shift_d  = startData;
         bitCnt_d = 3'd0;
         mode_d   = SM;
         tb8_d    = TB8;
      end
      ti_d = frameDone;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shift_q  <= 8'h00;
         bitCnt_q <= 3'd0;
         mode_q   <= MODE0;
         tb8_q    <= 1'b0;
         ti_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitCnt_q <= bitCnt_d;
         mode_q   <= mode_d;
         tb8_q    <= tb8_d;
         ti_q     <= ti_d;
      end
   end

`ifdef TX_HOLD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holdData_q <= 8'h00;
         holdFull_q <= 1'b0;
      end else begin
         holdData_q <= holdData_d;
         holdFull_q <= holdFull_d;
      end
   end
`endif

   // In mode 0 txd is the shift clock: low in the first half of each bit, high in the second.
   always_comb begin
      txd = 1'b1;
      case (state_q)
         START:   txd = 1'b0;
         DATA:    txd = (mode_q == MODE0) ? phase : shift_q[0];
         BIT9:    txd = tb8_q;
         default: txd = 1'b1;
      endcase
   end

   assign rxd_out = (state_q == DATA && mode_q == MODE0) ? shift_q[0] : 1'b1;
   assign rxd_oe  = busy && (mode_q == MODE0);
   assign TI      = ti_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit: a frame-level model counts TC/T7 ticks
// since each load and indexes the expected bit sequence.
module tb_uart_transmit;

   logic       clk = 1'b0;
   logic       rst_n, wr_n, TB8, TC, T7;
   logic [7:0] AB, din;
   logic [1:0] SM;
   logic       txd, rxd_out, rxd_oe, busy, TI;

   uart_transmit #(.SBUF_ADDR(8'h99), .OVS_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .AB(AB), .din(din), .wr_n(wr_n), .SM(SM),
      .TB8(TB8), .TC(TC), .T7(T7), .txd(txd), .rxd_out(rxd_out),
      .rxd_oe(rxd_oe), .busy(busy), .TI(TI)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, tiSeen = 0;
   int tcPeriod = 4, t7Period = 3;
   bit randTicks = 0;

   // Reference model: position in the frame is just ticks-since-load.
   bit         mBusy = 0, mSync = 0, mHoldFull = 0;
   int         mCnt = 0, mTotal = 0;
   logic       mBits [0:10];
   logic [7:0] mData = 8'h00, mHoldData = 8'h00;

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic modelStart(input logic [7:0] d, input logic [1:0] mode, input logic tb8);
      int n;
      mBusy = 1; mCnt = 0; mData = d; mSync = (mode == 2'd0);
      if (mSync) begin
         mTotal = 16;
      end else begin
         n = (mode == 2'd1) ? 10 : 11;
         mBits[0] = 1'b0;
         for (int i = 0; i < 8; i++) mBits[i+1] = d[i];
         if (n == 11) mBits[9] = tb8;
         mBits[n-1] = 1'b1;
         mTotal = 16 * n;
      end
   endtask

   task automatic checkOutput(input logic expTi);
      logic eTxd, eRxd, eOe;
      if (!mBusy) begin
         eTxd = 1'b1; eRxd = 1'b1; eOe = 1'b0;
      end else if (mSync) begin
         eTxd = ((mCnt % 2) == 1); eRxd = mData[mCnt/2]; eOe = 1'b1;
      end else begin
         eTxd = mBits[mCnt/16]; eRxd = 1'b1; eOe = 1'b0;
      end
      checkBit("busy", busy, mBusy);
      checkBit("TI", TI, expTi);
      checkBit("txd", txd, eTxd);
      checkBit("rxd_out", rxd_out, eRxd);
      checkBit("rxd_oe", rxd_oe, eOe);
      if (TI === 1'b1) tiSeen++;
   endtask

   // One clock: drive inputs, advance the model across the edge, check #1 after it.
   task automatic applyStimulus(input logic wrn, input logic [7:0] ab, input logic [7:0] d);
      logic       tc, t7, wr, doLoad, expTi, tb8Now;
      logic [1:0] smNow;
      if (randTicks) begin
         tc = ($urandom_range(0, 2) == 0);
         t7 = ($urandom_range(0, 2) == 0);
      end else begin
         tc = ((cyc % tcPeriod) == 0);
         t7 = ((cyc % t7Period) == 0);
      end
      wr_n = wrn; AB = ab; din = d; TC = tc; T7 = t7;
      wr = !wrn && (ab == 8'h99) && rst_n;
      doLoad = wr && !mBusy;
`ifdef TX_HOLD_EN
      if (wr && mBusy && !mHoldFull) begin
         mHoldFull = 1; mHoldData = d;
      end
`endif
      smNow = SM; tb8Now = TB8;
      @(posedge clk);
      #1;
      cyc++;
      expTi = 1'b0;
      if (!rst_n) begin
         mBusy = 0; mHoldFull = 0;
      end else if (doLoad) begin
         modelStart(d, smNow, tb8Now);
      end else if (mBusy) begin
         if (mSync ? t7 : tc) mCnt++;
         if (mCnt == mTotal) begin
            expTi = 1'b1;
            if (mHoldFull) begin
               modelStart(mHoldData, smNow, tb8Now);
               mHoldFull = 0;
            end else begin
               mBusy = 0;
            end
         end
      end
      checkOutput(expTi);
   endtask

   task automatic runFrame(input int maxCycles, input bit noisy);
      int  n = 0;
      bit  poked = 0;
      while ((mBusy || busy) && n < maxCycles) begin
         if (noisy && !poked && $urandom_range(0, 63) == 0) begin
            poked = 1;
            SM  = 2'($urandom_range(0, 3));
            TB8 = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, ($urandom_range(0, 1) == 1) ? 8'h99 : 8'h98, 8'($urandom));
         end else begin
            applyStimulus(1'b1, 8'h00, 8'h00);
         end
         n++;
      end
      checkBit("frameTimeout", busy, 1'b0);
   endtask

   task automatic sendFrame(input logic [1:0] mode, input logic tb8, input logic [7:0] d);
      SM = mode; TB8 = tb8;
      applyStimulus(1'b0, 8'h99, d);
      runFrame(4000, 1'b0);
   endtask

   initial begin
      int tiBefore;
      rst_n = 1'b0; wr_n = 1'b1; AB = 8'h00; din = 8'h00;
      SM = 2'd1; TB8 = 1'b0; TC = 1'b0; T7 = 1'b0;
      #2;
      checkOutput(1'b0);
      repeat (2) applyStimulus(1'b1, 8'h00, 8'h00);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b1, 8'h00, 8'h00);

      $display("[TB] mode 1 0xA5, mode 3 with TB8=1 and TB8=0, mode 0 0x81");
      tiBefore = tiSeen;
      sendFrame(2'd1, 1'b0, 8'hA5);
      checkInt("mode1TiCount", tiSeen - tiBefore, 1);
      sendFrame(2'd3, 1'b1, 8'h00);
      sendFrame(2'd3, 1'b0, 8'h00);
      tiBefore = tiSeen;
      sendFrame(2'd0, 1'b0, 8'h81);
      checkInt("mode0TiCount", tiSeen - tiBefore, 1);

      $display("[TB] write 0x55 during a 0xA5 frame");
      tiBefore = tiSeen;
      SM = 2'd1;
      applyStimulus(1'b0, 8'h99, 8'hA5);
      repeat (200) applyStimulus(1'b1, 8'h00, 8'h00);
      applyStimulus(1'b0, 8'h99, 8'h55);
      runFrame(4000, 1'b0);
`ifdef TX_HOLD_EN
      checkInt("holdTiCount", tiSeen - tiBefore, 2);
`else
      checkInt("holdTiCount", tiSeen - tiBefore, 1);
`endif

      $display("[TB] reset during data bit 4, then 0x3C");
      SM = 2'd1;
      applyStimulus(1'b0, 8'h99, 8'hE7);
      for (int i = 0; i < 2000 && mBusy && mCnt < 88; i++) applyStimulus(1'b1, 8'h00, 8'h00);
      checkInt("reachedBit4", mCnt, 88);
      rst_n = 1'b0;
      #1;
      mBusy = 0; mHoldFull = 0;
      checkBit("rstTxd", txd, 1'b1);
      checkBit("rstBusy", busy, 1'b0);
      checkBit("rstTI", TI, 1'b0);
      repeat (2) applyStimulus(1'b1, 8'h00, 8'h00);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b1, 8'h00, 8'h00);
      sendFrame(2'd1, 1'b0, 8'h3C);

      $display("[TB] SCON address write and mid-frame SM change");
      SM = 2'd1;
      applyStimulus(1'b0, 8'h98, 8'hFF);
      repeat (20) applyStimulus(1'b1, 8'h00, 8'h00);
      SM = 2'd2; TB8 = 1'b1;
      applyStimulus(1'b0, 8'h99, 8'hC3);
      repeat (100) applyStimulus(1'b1, 8'h00, 8'h00);
      SM = 2'd0; TB8 = 1'b0;
      runFrame(4000, 1'b0);

      $display("[TB] randomized frames");
      randTicks = 1;
      for (int f = 0; f < 8; f++) begin
         SM  = 2'($urandom_range(0, 3));
         TB8 = 1'($urandom_range(0, 1));
         applyStimulus(1'b0, 8'h99, 8'($urandom));
         runFrame(6000, 1'b1);
         repeat (3) applyStimulus(1'b1, 8'h00, 8'h00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_transmit.md
Name: uart_transmit

Overview:
- Transmit half of the 8051-style serial port; the counterpart of the SCON/SBUF receive path.
- A CPU write to SBUF starts one frame, serialised per SCON mode SM[1:0].
- Mode 0 is synchronous shift: data on rxd_out, shift clock on txd.
- Modes 1-3 are asynchronous: 10-bit frames (mode 1) or 11-bit frames (modes 2/3, 9th bit = TB8), timed from the shared 16x baud tick TC.

Parameters:
- SBUF_ADDR, 8'h99, SFR address that triggers a transmit on write.
- OVS_W, 4, oversample counter width; bit period = 2**OVS_W TC ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- AB  in  8  SFR address bus
- din  in  8  SFR write data
- wr_n  in  1  write strobe, active-low; one clk per access
- SM  in  2  SCON mode bits, sampled only at frame start
- TB8  in  1  9th data bit for modes 2/3, sampled at frame start
- TC  in  1  16x baud tick, one clk wide
- T7  in  1  mode-0 tick, one clk wide
- txd  out  1  serial data (modes 1-3) / shift clock (mode 0)
- rxd_out  out  1  mode-0 data output
- rxd_oe  out  1  mode-0 output enable for the RxD pad
- busy  out  1  frame in progress
- TI  out  1  one-clk pulse at end of frame; sets SCON.TI externally

Behaviour:
- Reset values: txd=1, rxd_out=1, rxd_oe=0, busy=0, TI=0, state=IDLE, counters=0.
- Load event: !wr_n && AB==SBUF_ADDR while IDLE.
  - Captures din into shift register, and latches SM and TB8.
  - busy=1 on the next clk.
  - A write while busy is ignored; no change to the frame in flight.
- States: IDLE, START, DATA, BIT9, STOP. All transitions occur on the bit tick.
- Bit tick, modes 1-3: OVS counter increments on TC; tick when counter==all-ones && TC.
  - Counter is cleared to 0 on load, so the START bit lasts exactly 16 TC ticks.
- Bit tick, mode 0: every second T7 (T7 phase toggles).
  - Phase 0: txd=0.
  - Phase 1: txd=1, giving a rising edge mid-bit.
  - Bit advances after phase 1.
- Transitions:
  - IDLE -> START on load (modes 1-3); IDLE -> DATA on load (mode 0).
  - START: txd=0; -> DATA on tick.
  - DATA: txd (or rxd_out in mode 0) = shift[0], LSB first; shift right on tick; 3-bit bit counter.
  - DATA exit after 8th bit: mode 0 -> IDLE; mode 1 -> STOP; modes 2/3 -> BIT9.
  - BIT9: txd=latched TB8; -> STOP on tick.
  - STOP: txd=1; -> IDLE on tick.
- TI is registered and pulses 1 clk after the final tick: end of STOP, or end of the 8th bit in mode 0.
- busy falls in the same cycle TI pulses.
- Mode 0: rxd_oe=1 from load until return to IDLE; txd idles high.
- Modes 1-3: rxd_oe=0 and rxd_out=1.
- SM changes mid-frame are ignored because the latched copy is used.
- Load coincident with TC: the counter clear wins; that TC tick is not counted.
- Asynchronous reset mid-frame aborts immediately to reset values; no TI pulse.

Optional Feature:
- TX_HOLD_EN defined:
  - Adds a one-entry holding register.
  - A write while busy and hold empty is stored and sets hold_full.
  - At the STOP-to-IDLE tick, the held byte is loaded directly into START with no idle bit-time, and TI still pulses for the finished frame.
  - A write while busy and hold full is dropped.
  - busy stays 1 across back-to-back frames.
- TX_HOLD_EN undefined: writes while busy are ignored, as described above.

Decomposition:
- Package uart_pkg:
  - state encodings IDLE/START/DATA/BIT9/STOP (3-bit)
  - mode constants MODE0..MODE3
  - SBUF address constants 8'h98/8'h99, shared with the receiver
- One natural sub-module: uart_tx_baud, holding the OVS counter plus mode-0 T7 phase toggle and producing bit_tick.

Test Plan:
- Mode 1, write 8'hA5, TC every 4 clk:
  - txd = 0, 1,0,1,0,0,1,0,1, 1; each bit 64 clk.
  - TI one pulse 1 clk after stop end; busy low the same cycle.
- Mode 3, TB8=1, write 8'h00 -> txd = 0, eight 0s, 1, 1 (11 bits); TB8=0 -> 9th bit 0.
- Mode 0, write 8'h81:
  - rxd_out = 1,0,0,0,0,0,0,1.
  - txd shows 8 low-high pulses; rxd_oe high only during the frame; TI after bit 8.
- Write 8'h55 mid-frame of 8'hA5:
  - Without TX_HOLD_EN: only 8'hA5 sent, one TI.
  - With TX_HOLD_EN: 8'h55 follows immediately, two TI pulses.
- rst_n low during DATA bit 4 -> txd=1, busy=0, no TI; a subsequent write 8'h3C transmits correctly.
- Write to AB=8'h98, and change SM mid-frame -> no transmit from the 8'h98 write; frame completes in its latched mode.
